// File: rtl/tcp_pkg.sv
// Shared TCP types and widths. The rx_buf_drain block uses the buffer-entry
// layout, the flow/index widths and its own state enum from here.
package tcp_pkg;

  localparam int FLOWID_W          = 8;
  localparam int RX_PAYLOAD_IDX_W  = 4;

  // Default walk cap for rx_buf_drain and the matching consumed-count width.
  localparam int RX_DRAIN_MAX_WALK = 8;
  localparam int RX_DRAIN_CNT_W    = $clog2(RX_DRAIN_MAX_WALK + 1);

  // One receive-buffer ring entry as held in the rx buffer store.
  typedef struct packed {
    logic        val;
    logic [31:0] seq;
    logic [15:0] size;
  } tcp_buf;

  typedef enum logic [2:0] {
    RXD_IDLE    = 3'd0,
    RXD_RD_REQ  = 3'd1,
    RXD_RD_WAIT = 3'd2,
    RXD_CLR     = 3'd3,
    RXD_DONE    = 3'd4
  } rx_drain_state_e;

endpackage

// File: rtl/rx_buf_drain.sv
// Walks one flow's rx buffer ring from its head index, consuming and clearing
// every entry that continues the in-order byte stream, then reports the
// advanced rcv_nxt, head index and number of buffers consumed.
module rx_buf_drain
  import tcp_pkg::*;
#(
  parameter int MAX_WALK = RX_DRAIN_MAX_WALK
) (
  input  logic                          clk,
  input  logic                          rst_n,
  // drain request
  input  logic                          req_val,
  output logic                          req_rdy,
  input  logic [FLOWID_W-1:0]           req_flowid,
  input  logic [31:0]                   req_rcv_nxt,
  input  logic [RX_PAYLOAD_IDX_W-1:0]   req_head_idx,
  // store read port
  output logic                          rd_req_val,
  input  logic                          rd_req_rdy,
  output logic [FLOWID_W-1:0]           rd_req_flowid,
  output logic [RX_PAYLOAD_IDX_W-1:0]   rd_req_idx,
  input  logic                          rd_resp_val,
  input  tcp_buf                        rd_resp_data,
  output logic                          rd_resp_rdy,
  // entry clear (muxed into the store write port outside this block)
  output logic                          clr_req_val,
  input  logic                          clr_req_rdy,
  output logic [FLOWID_W-1:0]           clr_req_flowid,
  output logic [RX_PAYLOAD_IDX_W-1:0]   clr_req_idx,
  output tcp_buf                        clr_req_data,
  // result
  output logic                          done_val,
  input  logic                          done_rdy,
  output logic [FLOWID_W-1:0]           done_flowid,
  output logic [31:0]                   done_rcv_nxt,
  output logic [RX_PAYLOAD_IDX_W-1:0]   done_head_idx,
  output logic [$clog2(MAX_WALK+1)-1:0] done_cnt
);

  localparam int CNT_W = $clog2(MAX_WALK + 1);

  rx_drain_state_e               state_q;
  logic [FLOWID_W-1:0]           flowid_q;
  logic [31:0]                   rcv_nxt_q;
  logic [RX_PAYLOAD_IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]              cnt_q;
  logic [15:0]                   size_q;

  logic [CNT_W-1:0] cnt_d;
  logic             hit;

  assign cnt_d = cnt_q + CNT_W'(1);

  // A zero-size entry never advances rcv_nxt, so treating it as a miss keeps
  // the walk from spinning on it. Wrap is handled by plain 32-bit equality.
  assign hit = rd_resp_data.val && (rd_resp_data.seq == rcv_nxt_q) &&
               (rd_resp_data.size != 16'd0);

  // Walk control: one read outstanding at a time, clear completes before the
  // next read is issued, result held until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RXD_IDLE;
      flowid_q  <= '0;
      rcv_nxt_q <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
    end else begin
      case (state_q)
        RXD_IDLE: if (req_val) begin
          flowid_q  <= req_flowid;
          rcv_nxt_q <= req_rcv_nxt;
          idx_q     <= req_head_idx;
          cnt_q     <= '0;
          state_q   <= RXD_RD_REQ;
        end
        RXD_RD_REQ: if (rd_req_rdy) state_q <= RXD_RD_WAIT;
        RXD_RD_WAIT: if (rd_resp_val) begin
          if (hit) begin
            size_q  <= rd_resp_data.size;
            state_q <= RXD_CLR;
          end else begin
            state_q <= RXD_DONE;
          end
        end
        RXD_CLR: if (clr_req_rdy) begin
          rcv_nxt_q <= rcv_nxt_q + 32'(size_q);
          idx_q     <= idx_q + RX_PAYLOAD_IDX_W'(1);
          cnt_q     <= cnt_d;
          state_q   <= (cnt_d == CNT_W'(MAX_WALK)) ? RXD_DONE : RXD_RD_REQ;
        end
        RXD_DONE: if (done_rdy) state_q <= RXD_IDLE;
        default: state_q <= RXD_IDLE;
      endcase
    end
  end

  // Handshake strobes decode straight from the state register; data outputs
  // come from the latched walk registers, so they hold until accepted.
  assign req_rdy        = (state_q == RXD_IDLE);
  assign rd_req_val     = (state_q == RXD_RD_REQ);
  assign rd_resp_rdy    = (state_q == RXD_RD_WAIT);
  assign clr_req_val    = (state_q == RXD_CLR);
  assign done_val       = (state_q == RXD_DONE);

  assign rd_req_flowid  = flowid_q;
  assign rd_req_idx     = idx_q;
  assign clr_req_flowid = flowid_q;
  assign clr_req_idx    = idx_q;
  assign clr_req_data   = '0;

  assign done_flowid    = flowid_q;
  assign done_rcv_nxt   = rcv_nxt_q;
  assign done_head_idx  = idx_q;
  assign done_cnt       = cnt_q;

endmodule

// File: doc/rx_buf_drain.md
# rx_buf_drain

Walks one flow's receive-buffer ring in order, starting at the flow's head index. Consumes every buffer whose sequence number continues the in-order byte stream, clears each consumed entry, and reports the advanced `rcv_nxt` and head index. It sits directly downstream of the rx buffer store: it owns one of that store's read ports, and its clear port is muxed into the store's write port. The result feeds the ACK/`rcv_nxt` update and app-notification path.

## Interface
- `MAX_WALK`, default 8: maximum buffers consumed per request; must be ≥1.
- `FLOWID_W`, `RX_PAYLOAD_IDX_W`, `tcp_buf`: taken from `tcp_pkg`, not parameters.
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_val` in 1, `req_rdy` out 1: drain request handshake.
- `req_flowid` in FLOWID_W: flow to drain.
- `req_rcv_nxt` in 32: current in-order next expected sequence number.
- `req_head_idx` in RX_PAYLOAD_IDX_W: ring index of the oldest unconsumed buffer.
- `rd_req_val` out 1, `rd_req_rdy` in 1, `rd_req_flowid` out FLOWID_W, `rd_req_idx` out RX_PAYLOAD_IDX_W: store read request.
- `rd_resp_val` in 1, `rd_resp_data` in tcp_buf, `rd_resp_rdy` out 1: store read response.
- `clr_req_val` out 1, `clr_req_rdy` in 1, `clr_req_flowid` out FLOWID_W, `clr_req_idx` out RX_PAYLOAD_IDX_W, `clr_req_data` out tcp_buf: entry-clear write. `clr_req_data` is all-zero, so `val`=0.
- `done_val` out 1, `done_rdy` in 1: result handshake.
- `done_flowid` out FLOWID_W: flow the result belongs to.
- `done_rcv_nxt` out 32: advanced next expected sequence number.
- `done_head_idx` out RX_PAYLOAD_IDX_W: advanced head index.
- `done_cnt` out $clog2(MAX_WALK+1): number of buffers consumed.

## Operation
- The FSM has five states: IDLE, RD_REQ, RD_WAIT, CLR, DONE.
- IDLE:
  - `req_rdy`=1.
  - On `req_val` & `req_rdy`, latch flowid, `rcv_nxt` and idx, zero `cnt`, and go to RD_REQ.
- RD_REQ:
  - `rd_req_val`=1 with the latched flowid and current idx.
  - On `rd_req_rdy`, go to RD_WAIT.
- RD_WAIT:
  - `rd_resp_rdy`=1.
  - On `rd_resp_val`, test the entry: hit if `val`==1, `seq`==`rcv_nxt` (exact 32-bit equality) and `size`!=0.
  - Hit: latch `size` and go to CLR.
  - Miss: go to DONE.
- CLR:
  - `clr_req_val`=1 at the current idx.
  - On `clr_req_rdy`:
    - `rcv_nxt` += `size`, modulo 2^32.
    - idx += 1, modulo 2^RX_PAYLOAD_IDX_W (ring wrap).
    - `cnt` += 1.
  - Then go to DONE if the new `cnt`==MAX_WALK, otherwise go to RD_REQ.
- DONE:
  - `done_val`=1 with the latched values.
  - On `done_rdy`, go to IDLE.
- Boundary rules:
  - A zero-size valid entry is a miss. This prevents a non-advancing loop.
  - A stale entry (`val`=1, `seq`!=`rcv_nxt`) is a miss and is not cleared.
  - An empty ring returns `done_cnt`=0 with `rcv_nxt` and idx unchanged.
  - Sequence wrap past 2^32-1 is handled purely by modular add and equality compare.
- Only one request is in flight at a time. Exactly one read is outstanding in RD_WAIT and none elsewhere.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - State goes to IDLE.
  - `req_rdy`=1 once reset is released.
  - All other outputs are 0: `rd_req_val`, `rd_resp_rdy`, `clr_req_val`, `done_val`, and all data outputs.
- Reset mid-walk abandons the walk with no result. The store must share this reset domain, so no stale response can arrive.
- All outputs are registered-state decodes, with no combinational path from an input `val` to an output `val`.
- Valid/data are held stable until the handshake completes.
- Latency, for a store with 1-cycle read latency and all readys held high, counting from the accept edge:
  - Empty walk: 3 cycles to `done_val` (RD_REQ, RD_WAIT, DONE).
  - Each consumed buffer adds 3 cycles (RD_REQ, RD_WAIT, CLR).
  - The final miss read adds 2 cycles, unless `MAX_WALK` terminates the walk.
- The clear of entry k completes before the read of entry k+1 is issued, so the write port is never contended by this block against itself.

## Structure
- Add to `tcp_pkg`:
  - `RX_DRAIN_CNT_W`.
  - The `tcp_buf` field accessors already defined there (`val`, `seq`, `size`) are used unchanged.
  - A `rx_drain_state_e` enum for the five states.
- Single module, no sub-module. The write-port mux with the ingress writer lives outside this block.

## Test plan
- **Empty ring:** req `flowid`=3, `rcv_nxt`=0x1000, idx=5; entry 5 has `val`=0 → `done_cnt`=0, `rcv_nxt`=0x1000, idx=5; no clear issued.
- **Three in-order buffers:** idx 5/6/7 hold seq 0x1000/0x1200/0x1300, sizes 0x200/0x100/0x80; entry 8 is invalid → `cnt`=3, `rcv_nxt`=0x1380, idx=8; clears issued at 5, 6 and 7 in that order.
- **Gap:** entry 5 has seq 0x1400 while `rcv_nxt`=0x1000 → `cnt`=0; entry 5 is not cleared.
- **Wrap:**
  - Index wrap: idx=2^RX_PAYLOAD_IDX_W−1 holds a hit and idx 0 holds a hit → `done_head_idx`=1.
  - Sequence wrap: seq 0xFFFFFF00 with size 0x200 → `rcv_nxt`=0x100.
- **MAX_WALK cap:** 10 contiguous hits with `MAX_WALK`=8 → `cnt`=8 and exactly 8 clears; entry 9 is not read.
- **Backpressure:**
  - Random deassertion of `rd_req_rdy`, `clr_req_rdy` and `done_rdy` gives the same results as the unstalled runs.
  - `rst_n` pulsed low in CLR returns to IDLE with all valid outputs 0 at the next cycle.
